dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder for the CPU load/store port: answers word requests on a valid/ready request channel and a valid/ready response channel.
- Adds programmable wait states and byte-lane write enables.
- Storage is four byte-lane arrays, so the bench can preload and inspect memory hierarchically.
- Detects the end-of-simulation signature write and exports a sticky done flag plus a committed-write counter. Instantiated in top in place of the plain DM.

Parameters:
ADDR_W, 14, word-address width (2^ADDR_W words)
WAIT_STATES, 1, extra cycles between request accept and memory commit (0..15)
SIM_END_ADDR, 14'h3FFF, word address of the end-of-simulation mailbox
SIM_END_CODE, 32'hFFFFFFFF, value that signals end of simulation

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  4  byte write enables [3]=bits 31:24 … [0]=bits 7:0; 4'b0000 = read
req_addr  in  ADDR_W  word address
req_wdata  in  32  write data
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts the response
rsp_rdata  out  32  word at req_addr after the access
sim_done  out  1  sticky, mailbox holds SIM_END_CODE
wr_count  out  32  number of committed writes, saturating

Behaviour:
- Storage: arrays Memory_byte0..Memory_byte3, each 2^ADDR_W x 8. Lane n holds bits 8n+7:8n. Arrays are not cleared by reset. Contents survive reset.
- Reset (rst=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, sim_done=0, wr_count=0, wait counter=0. A request in flight is dropped, with no commit unless the commit edge already occurred.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, capture addr/we/wdata. Go to WAIT if WAIT_STATES>0 (counter=WAIT_STATES-1), else commit on that same edge and go to RESP.
- WAIT: req_ready=0. Decrement the counter each edge. On the edge where counter==0, commit and go to RESP.
- RESP: req_ready=0, rsp_valid=1. rsp_rdata stays stable until an edge with rsp_ready=1, which moves the FSM to IDLE.
- No back-to-back acceptance: a new request can only be accepted from IDLE, so throughput is one per (WAIT_STATES+2) cycles minimum.
- Latency: request accepted at edge N gives rsp_valid=1 starting the cycle after edge N+WAIT_STATES.
- Commit, write (any we bit set): update only the enabled lanes. rsp_rdata = the resulting full word, with merged old bytes for disabled lanes. wr_count += 1, saturating at 32'hFFFFFFFF.
- Commit, read (we=0): rsp_rdata = stored word. wr_count is unchanged.
- sim_done: set on the commit edge of a write to SIM_END_ADDR whose resulting word equals SIM_END_CODE. This includes a partial write completing the code. It stays 1 until reset, and later writes do not clear it. Mailbox preloaded by $readmemh does not set it.
- Address width: req_addr uses exactly ADDR_W bits, so there is no out-of-range case. Reads of never-written locations return X in simulation; this is acceptable.
- req_valid dropping while in WAIT/RESP is ignored; the captured request completes.

Decomposition:
- Shared package dm_pkg:
  - FSM state enum (IDLE/WAIT/RESP)
  - byte-enable constants: BE_WORD=4'b1111, BE_NONE=4'b0000
  - default SIM_END_ADDR / SIM_END_CODE
- One natural sub-module, dm_byte_lane: an 8-bit-wide array with write enable and synchronous read. It is instantiated four times, with the array instance names Memory_byte0..3 preserved for bench access.

Test Plan:
- Reset then idle: rst=0 for 2 cycles → req_ready=1, rsp_valid=0, sim_done=0, wr_count=0.
- Word write/read, WAIT_STATES=1: write addr 0x2000, we=4'hF, data 0x12345678 at edge N → rsp_valid from edge N+1, rsp_rdata=0x12345678, wr_count=1. Then read 0x2000 → rsp_rdata=0x12345678, wr_count still 1.
- Byte merge: 0x2001 holds 0xAABBCCDD; write we=4'b0101, data 0x11223344 → stored word and rsp_rdata = 0xAA22CC44.
- Response backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid stays 1, rsp_rdata stable, req_ready=0. A second req_valid is not accepted until the cycle after rsp_ready=1.
- Signature: write 0xFFFFFFFF to 0x3FFF → sim_done=1 after the commit edge. Then write 0 to 0x3FFF → sim_done stays 1. Then assert rst → sim_done=0 while Memory_byte0[0x3FFF]=0x00 is retained.
- Reset mid-operation, WAIT_STATES=3: accept a write to 0x2002, assert rst one cycle later → no commit (location unchanged), state IDLE, wr_count=0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM states,
// byte-enable constants, mailbox defaults and a saturating counter helper.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  localparam logic [3:0]  BE_WORD = 4'b1111;
  localparam logic [3:0]  BE_NONE = 4'b0000;

  localparam logic [13:0] DEF_SIM_END_ADDR = 14'h3FFF;
  localparam logic [31:0] DEF_SIM_END_CODE = 32'hFFFFFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// One byte lane of data memory: 2^ADDR_W x 8 array with write enable and
// a registered, write-first read port. The read register returns the new
// byte on a write and the stored byte otherwise, so the four lanes together
// present the merged word the cycle after a commit.
module dm_byte_lane #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  // Storage is deliberately never reset so contents survive rst.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] rdata_reg;

  // Array write port.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port, write-first; only the output register is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg <= '0;
    end else if (en) begin
      rdata_reg <= we ? wdata : mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the CPU load/store port. Accepts one word
// request at a time, waits WAIT_STATES cycles, commits to four byte lanes,
// then holds the response until the requester takes it. Also flags the
// end-of-simulation mailbox write and counts committed writes.
module dm_responder
  import dm_pkg::*;
#(
  parameter int                ADDR_W       = 14,
  parameter int                WAIT_STATES  = 1,
  parameter logic [ADDR_W-1:0] SIM_END_ADDR = ADDR_W'(DEF_SIM_END_ADDR),
  parameter logic [31:0]       SIM_END_CODE = DEF_SIM_END_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              sim_done,
  output logic [31:0]       wr_count
);

  dm_state_t         state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        we_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       wr_count_reg;
  logic              mbox_chk_reg;
  logic              done_reg;

  logic              accept;
  logic              commit;
  logic              commit_en;
  logic [ADDR_W-1:0] cmt_addr;
  logic [3:0]        cmt_we;
  logic [31:0]       cmt_wdata;
  logic [31:0]       lane_rdata;

  // With zero wait states the commit happens on the accept edge, so the
  // lanes must see the live request; otherwise they see the captured one.
  assign cmt_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign cmt_we    = (state_reg == IDLE) ? req_we    : we_reg;
  assign cmt_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

  // Never write the arrays while reset is held.
  assign commit_en = commit & rst;

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = 4'(WAIT_STATES - 1);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, wait counter and captured request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      we_reg    <= BE_NONE;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= req_addr;
        we_reg    <= req_we;
        wdata_reg <= req_wdata;
      end
    end
  end

  // Write counter and end-of-simulation detection. The merged mailbox word
  // only exists in the lane read registers after the commit edge, so the
  // commit arms a one-cycle check and sim_done includes that check directly,
  // making it visible right after the commit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count_reg <= '0;
      mbox_chk_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      if (commit && (cmt_we != BE_NONE)) begin
        wr_count_reg <= sat_inc(wr_count_reg);
      end
      mbox_chk_reg <= commit && (cmt_we != BE_NONE) && (cmt_addr == SIM_END_ADDR);
      if (sim_done) begin
        done_reg <= 1'b1;
      end
    end
  end

  assign sim_done  = done_reg | (mbox_chk_reg && (lane_rdata == SIM_END_CODE));
  assign wr_count  = wr_count_reg;
  assign rsp_rdata = lane_rdata;

  dm_byte_lane #(.ADDR_W(ADDR_W)) Memory_byte0 (
    .clk(clk), .rst(rst), .en(commit_en), .we(cmt_we[0]), .addr(cmt_addr),
    .wdata(cmt_wdata[7:0]), .rdata(lane_rdata[7:0])
  );
  dm_byte_lane #(.ADDR_W(ADDR_W)) Memory_byte1 (
    .clk(clk), .rst(rst), .en(commit_en), .we(cmt_we[1]), .addr(cmt_addr),
    .wdata(cmt_wdata[15:8]), .rdata(lane_rdata[15:8])
  );
  dm_byte_lane #(.ADDR_W(ADDR_W)) Memory_byte2 (
    .clk(clk), .rst(rst), .en(commit_en), .we(cmt_we[2]), .addr(cmt_addr),
    .wdata(cmt_wdata[23:16]), .rdata(lane_rdata[23:16])
  );
  dm_byte_lane #(.ADDR_W(ADDR_W)) Memory_byte3 (
    .clk(clk), .rst(rst), .en(commit_en), .we(cmt_we[3]), .addr(cmt_addr),
    .wdata(cmt_wdata[31:24]), .rdata(lane_rdata[31:24])
  );

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a WAIT_STATES=1 instance driven through a
// scoreboard, plus a WAIT_STATES=3 instance for the mid-operation reset.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int WS_A = 1;
  localparam int WS_B = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_we = 4'h0;
  logic [13:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        sim_done;
  logic [31:0] wr_count;

  // Instance B signals
  logic        b_rst = 1'b0;
  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic [3:0]  b_req_we = 4'h0;
  logic [13:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b0;
  logic [31:0] b_rsp_rdata;
  logic        b_sim_done;
  logic [31:0] b_wr_count;

  dm_responder #(.ADDR_W(14), .WAIT_STATES(WS_A)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sim_done(sim_done), .wr_count(wr_count)
  );

  dm_responder #(.ADDR_W(14), .WAIT_STATES(WS_B)) dut3 (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .sim_done(b_sim_done), .wr_count(b_wr_count)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard entries and reference model
  typedef struct packed {
    logic [13:0] addr;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic [31:0] wcnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model_mem [int];
  logic [31:0] model_wcnt = 32'd0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Response monitor: pops the scoreboard on each handshake
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn addr=%h we=%h rdata=%h exp=%h wr_count=%0d", mon_e.addr, mon_e.we,
                 rsp_rdata, mon_e.rdata, wr_count);
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_wr_count", wr_count, mon_e.wcnt);
      end
    end
  end

  // One request on instance A; hold = cycles of response backpressure
  task automatic do_req(input logic [3:0] we, input logic [13:0] addr,
                        input logic [31:0] wdata, input int hold);
    int k;
    logic [31:0] old_w, exp_w, snap;
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    old_w = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : 32'h0;
    exp_w = (we == BE_NONE) ? old_w : merge(old_w, wdata, we);
    if (we != BE_NONE) begin
      model_mem[int'(addr)] = exp_w;
      if (model_wcnt != 32'hFFFFFFFF) model_wcnt = model_wcnt + 32'd1;
    end
    e.addr = addr; e.we = we; e.rdata = exp_w; e.wcnt = model_wcnt;
    sb_q.push_back(e);
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    chk("latency", 32'(k), 32'(WS_A));
    if (!rsp_valid) return;
    snap = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata_stable", rsp_rdata, snap);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  // One full request on instance B, returning the response word
  task automatic b_req(input logic [3:0] we, input logic [13:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata);
    int k;
    rdata = 32'h0;
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
    k = 0;
    @(negedge clk);
    while (!b_req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!b_rsp_valid && k < 50) begin @(negedge clk); k++; end
    chk("b_latency", 32'(k), 32'(WS_B));
    rdata = b_rsp_rdata;
    @(posedge clk); #1;
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] w;
    logic [3:0]  be;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_sim_done", {31'd0, sim_done}, 32'd0);
    chk("rst_wr_count", wr_count, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; b_rst = 1'b1;

    // Word write then read
    do_req(BE_WORD, 14'h2000, 32'h12345678, 0);
    do_req(BE_NONE, 14'h2000, 32'h0, 0);

    // Byte merge, then read back under backpressure
    do_req(BE_WORD, 14'h2001, 32'hAABBCCDD, 0);
    do_req(4'b0101, 14'h2001, 32'h11223344, 0);
    do_req(BE_NONE, 14'h2001, 32'h0, 5);
    chk("mem_merge_b2", {24'd0, dut.Memory_byte2.mem[14'h2001]}, 32'h22);
    chk("mem_merge_b3", {24'd0, dut.Memory_byte3.mem[14'h2001]}, 32'hAA);
    chk("no_done_yet", {31'd0, sim_done}, 32'd0);

    // Mailbox: partial write completes the code, then sticky
    do_req(BE_WORD, 14'h3FFF, 32'h0000FFFF, 0);
    chk("done_partial_not_yet", {31'd0, sim_done}, 32'd0);
    do_req(4'b1100, 14'h3FFF, 32'hFFFF0000, 0);
    chk("done_set", {31'd0, sim_done}, 32'd1);
    do_req(BE_WORD, 14'h3FFF, 32'h00000000, 0);
    chk("done_sticky", {31'd0, sim_done}, 32'd1);

    // Reset clears flags but keeps memory
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_sim_done", {31'd0, sim_done}, 32'd0);
    chk("rst2_wr_count", wr_count, 32'd0);
    chk("rst2_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst2_mem_kept", {24'd0, dut.Memory_byte0.mem[14'h3FFF]}, 32'h0);
    model_wcnt = 32'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_req(BE_NONE, 14'h3FFF, 32'h0, 0);
    do_req(BE_NONE, 14'h2000, 32'h0, 0);

    // Random byte-enable traffic over a small initialised window
    for (int i = 0; i < 4; i++) do_req(BE_WORD, 14'h0100 + 14'(i), $urandom, 0);
    for (int i = 0; i < 10; i++) begin
      be = 4'($urandom_range(0, 15));
      w  = $urandom;
      do_req(be, 14'h0100 + 14'($urandom_range(0, 3)), w, (i == 3) ? 2 : 0);
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // Instance B: reset one cycle after accepting a write drops it
    b_req(BE_WORD, 14'h2002, 32'h0BADF00D, rd);
    chk("b_first_rdata", rd, 32'h0BADF00D);
    chk("b_wr_count_1", b_wr_count, 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_we = BE_WORD; b_req_addr = 14'h2002; b_req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("b_ready_before", {31'd0, b_req_ready}, 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("b_busy", {31'd0, b_req_ready}, 32'd0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(negedge clk);
    chk("b_rst_ready", {31'd0, b_req_ready}, 32'd1);
    chk("b_rst_wr_count", b_wr_count, 32'd0);
    chk("b_rst_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    b_rst = 1'b1;
    @(negedge clk);
    chk("b_mem_unchanged", {dut3.Memory_byte3.mem[14'h2002], dut3.Memory_byte2.mem[14'h2002],
                            dut3.Memory_byte1.mem[14'h2002], dut3.Memory_byte0.mem[14'h2002]},
        32'h0BADF00D);
    b_req(BE_NONE, 14'h2002, 32'h0, rd);
    chk("b_read_back", rd, 32'h0BADF00D);
    chk("b_wr_count_after", b_wr_count, 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
